datapath_unit: RTL

Execution datapath directly downstream of the control unit. It consumes the control unit's per-cycle control word (register addresses, write enable, write-source select, ALU op, data-memory address and write strobe) and performs the register, ALU and data-memory work for each instruction. It contains a 16×16 register file, a 16-bit ALU, a 256×16 synchronous data memory and the write-back mux.

---
 rtl/datapath_pkg.sv | 43 ++++
 rtl/datapath_unit_register_file.sv | 33 +++
 rtl/datapath_unit.sv | 72 +++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// Shared datapath constants and ALU opcode encoding, used by the datapath and
// the control unit so opcode-to-ALU_s0 mappings live in one place.
package datapath_pkg;

    localparam int DATA_W   = 16;
    localparam int RF_DEPTH = 16;
    localparam int DM_DEPTH = 256;
    localparam int RF_AW    = $clog2(RF_DEPTH);
    localparam int DM_AW    = $clog2(DM_DEPTH);

    typedef enum logic [2:0] {
        ALU_ZERO  = 3'b000,
        ALU_ADD   = 3'b001,
        ALU_SUB   = 3'b010,
        ALU_PASSA = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_AND   = 3'b110,
        ALU_INC   = 3'b111
    } alu_op_e;

    // Carry and borrow fall off the top: all arithmetic wraps modulo 2^DATA_W.
    function automatic logic [DATA_W-1:0] alu_eval(
        input alu_op_e           op,
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W-1:0] res;
        case (op)
            ALU_ZERO:  res = {DATA_W{1'b0}};
            ALU_ADD:   res = a + b;
            ALU_SUB:   res = a - b;
            ALU_PASSA: res = a;
            ALU_XOR:   res = a ^ b;
            ALU_OR:    res = a | b;
            ALU_AND:   res = a & b;
            ALU_INC:   res = a + 16'd1;
            default:   res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

endpackage

// File: rtl/datapath_unit_register_file.sv
// 2-read / 1-write register file with asynchronous reads and a synchronous,
// active-low clear. Reads never bypass a same-edge write.
module register_file
    import datapath_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [RF_AW-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [RF_AW-1:0]  raddr_a_i,
    input  logic [RF_AW-1:0]  raddr_b_i,
    output logic [DATA_W-1:0] rdata_a_o,
    output logic [DATA_W-1:0] rdata_b_o
);

    logic [DATA_W-1:0] regs_q [RF_DEPTH];

    // Register array: clear on reset, otherwise single-port write.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = regs_q[raddr_a_i];
    assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, ALU, write-back mux and a synchronous
// data memory driven by the control unit's per-cycle control word.
module datapath_unit
    import datapath_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset,
    input  logic [DM_AW-1:0]  D_Addr,
    input  logic              D_Wr,
    input  logic              RF_s,
    input  logic [RF_AW-1:0]  RF_W_Addr,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_Ra_Addr,
    input  logic [RF_AW-1:0]  RF_Rb_Addr,
    input  logic [2:0]        ALU_s0,
    output logic [DATA_W-1:0] Ra_Data,
    output logic [DATA_W-1:0] Rb_Data,
    output logic [DATA_W-1:0] ALU_Out,
    output logic              ALU_Zero,
    output logic [DATA_W-1:0] Mem_Q
);

    logic [DATA_W-1:0] alu_out_s;
    logic [DATA_W-1:0] w_data_s;
    logic [DATA_W-1:0] mem_q_q;
    logic [DATA_W-1:0] mem_q_d;
    logic [DATA_W-1:0] dmem_q [DM_DEPTH];

    register_file u_register_file (
        .clk_i     (Clk),
        .rst_n_i   (Reset),
        .we_i      (RF_W_en),
        .waddr_i   (RF_W_Addr),
        .wdata_i   (w_data_s),
        .raddr_a_i (RF_Ra_Addr),
        .raddr_b_i (RF_Rb_Addr),
        .rdata_a_o (Ra_Data),
        .rdata_b_o (Rb_Data)
    );

    // ALU and write-back select.
    always_comb begin
        alu_out_s = alu_eval(alu_op_e'(ALU_s0), Ra_Data, Rb_Data);
        if (RF_s) begin
            w_data_s = mem_q_q;
        end else begin
            w_data_s = alu_out_s;
        end
        mem_q_d = dmem_q[D_Addr];
    end

    // Read data register; the array read happens before any same-edge write.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            mem_q_q <= {DATA_W{1'b0}};
        end else begin
            mem_q_q <= mem_q_d;
        end
    end

    // Memory contents survive reset; only the store is blocked.
    always_ff @(posedge Clk) begin
        if (Reset && D_Wr) begin
            dmem_q[D_Addr] <= Ra_Data;
        end
    end

    assign ALU_Out  = alu_out_s;
    assign ALU_Zero = (alu_out_s == {DATA_W{1'b0}});
    assign Mem_Q    = mem_q_q;

endmodule
